// File: rtl/led_cmd_ctrl.sv
// led_cmd_ctrl -- command executor between a SPI frame decoder and a PWM bank.
// Decoded frames are queued in a small FIFO; a three-state FSM pops one frame
// at a time, updates the LED brightness registers or builds a read response,
// and holds that response until the SPI slave acknowledges it.
//
// Ports
//   sysclk        sole clock, rising edge
//   rst           synchronous active-high reset
//   i_rx_dv       one-cycle pulse: i_cmd/i_addr/i_payload hold a decoded frame
//   i_cmd         command (0 NOP, 1 LED_SET, 2 LED_READ, others illegal)
//   i_addr        LED index
//   i_payload     payload; brightness is payload[7:1]
//   i_tx_ack      SPI slave has taken o_tx_frame
//   o_tx_valid    response frame pending
//   o_tx_frame    response {cmd, addr, payload}
//   o_brightness  flat brightness bus, LED n at [7n+6:7n]
//   o_fifo_full   command queue full
//   o_err_cnt     saturating count of illegal commands / addresses
//   o_drop_cnt    saturating count of frames dropped on a full queue
module led_cmd_ctrl #(
  parameter int CMD_W      = 4,
  parameter int ADDR_W     = 4,
  parameter int PAYLOAD_W  = 8,
  parameter int NUM_LEDS   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                sysclk,
  input  logic                                rst,
  input  logic                                i_rx_dv,
  input  logic [CMD_W-1:0]                    i_cmd,
  input  logic [ADDR_W-1:0]                   i_addr,
  input  logic [PAYLOAD_W-1:0]                i_payload,
  input  logic                                i_tx_ack,
  output logic                                o_tx_valid,
  output logic [CMD_W+ADDR_W+PAYLOAD_W-1:0]   o_tx_frame,
  output logic [NUM_LEDS*7-1:0]               o_brightness,
  output logic                                o_fifo_full,
  output logic [7:0]                          o_err_cnt,
  output logic [7:0]                          o_drop_cnt
);

  localparam int FRAME_W = CMD_W + ADDR_W + PAYLOAD_W;
  localparam int PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW      = $clog2(FIFO_DEPTH + 1);
  localparam int LW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [CMD_W-1:0] CMD_NOP  = CMD_W'(0);
  localparam logic [CMD_W-1:0] CMD_SET  = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_READ = CMD_W'(2);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  // ---------------- command queue ----------------
  logic [FRAME_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [7:0]         r_drop_cnt;
  state_t             r_state;

  logic w_empty, w_full, w_pop, w_push, w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  // A full queue still accepts a frame when the head leaves on the same edge.
  assign w_push  = i_rx_dv && (!w_full || w_pop);
  assign w_drop  = i_rx_dv && w_full && !w_pop;

  always_ff @(posedge sysclk) begin
    if (w_push && !rst) r_mem[r_wr_ptr] <= {i_cmd, i_addr, i_payload};
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  // ---------------- executor FSM ----------------
  logic [CMD_W-1:0]               r_cmd;
  logic [ADDR_W-1:0]              r_addr;
  logic [PAYLOAD_W-1:0]           r_payload;
  logic [NUM_LEDS-1:0][6:0]       r_bright;
  logic                           r_tx_valid;
  logic [FRAME_W-1:0]             r_tx_frame;
  logic [7:0]                     r_err_cnt;

  logic                 w_addr_ok;
  logic [LW-1:0]        w_led;
  logic [PAYLOAD_W-1:0] w_rd_pay;
  logic [7:0]           w_err_inc;
  logic                 w_unused;

  assign w_addr_ok = 32'(r_addr) < NUM_LEDS;
  assign w_led     = r_addr[LW-1:0];
  assign w_rd_pay  = PAYLOAD_W'({r_bright[w_led], 1'b0});
  assign w_err_inc = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 1'b1;
  // Payload bit 0 carries no brightness information.
  assign w_unused  = r_payload[0];

  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cmd      <= '0;
      r_addr     <= '0;
      r_payload  <= '0;
      r_bright   <= '0;
      r_tx_valid <= 1'b0;
      r_tx_frame <= '0;
      r_err_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_cmd, r_addr, r_payload} <= r_mem[r_rd_ptr];
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_state <= S_IDLE;
          case (r_cmd)
            CMD_NOP: ;
            CMD_SET: begin
              if (w_addr_ok) r_bright[w_led] <= r_payload[7:1];
              else           r_err_cnt       <= w_err_inc;
            end
            CMD_READ: begin
              r_tx_valid <= 1'b1;
              r_state    <= S_RESP;
              if (w_addr_ok) begin
                r_tx_frame <= {r_cmd, r_addr, w_rd_pay};
              end else begin
                r_tx_frame <= {r_cmd, r_addr, {PAYLOAD_W{1'b1}}};
                r_err_cnt  <= w_err_inc;
              end
            end
            default: r_err_cnt <= w_err_inc;
          endcase
        end
        S_RESP: begin
          if (i_tx_ack) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx_valid   = r_tx_valid;
  assign o_tx_frame   = r_tx_frame;
  assign o_brightness = r_bright;
  assign o_fifo_full  = w_full;
  assign o_err_cnt    = r_err_cnt;
  assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_led_cmd_ctrl.sv
// Bench for led_cmd_ctrl: a directed vector table, hand-written multi-cycle
// sequences, and a randomized run checked against a behavioural model.
module tb_led_cmd_ctrl;

  logic        sysclk = 1'b0;
  logic        rst = 1'b0, dv = 1'b0, ack = 1'b0;
  logic [3:0]  cmd = '0, addr = '0;
  logic [7:0]  pay = '0;
  logic        tx_valid, fifo_full;
  logic [15:0] tx_frame;
  logic [55:0] bright;
  logic [7:0]  err_cnt, drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sysclk = ~sysclk;

  led_cmd_ctrl dut (
    .sysclk(sysclk), .rst(rst), .i_rx_dv(dv), .i_cmd(cmd), .i_addr(addr),
    .i_payload(pay), .i_tx_ack(ack), .o_tx_valid(tx_valid), .o_tx_frame(tx_frame),
    .o_brightness(bright), .o_fifo_full(fifo_full), .o_err_cnt(err_cnt),
    .o_drop_cnt(drop_cnt)
  );

  // ---------------- behavioural model ----------------
  // phase: 0 waiting for work, 1 executing the held frame, 2 response out
  int          m_phase;
  logic [15:0] m_cur;
  logic [15:0] mq[$];
  logic [6:0]  m_b[8];
  int          m_err, m_drop;
  logic        m_valid;
  logic [15:0] m_frame;

  function automatic void m_err_bump();
    if (m_err < 255) m_err++;
  endfunction

  function automatic void model_step(logic r, logic d, logic [15:0] f, logic k);
    int sz0;
    bit pop;
    logic [3:0] c, a;
    logic [7:0] p;
    if (r) begin
      mq.delete(); m_phase = 0; m_valid = 0; m_frame = '0; m_err = 0; m_drop = 0;
      foreach (m_b[i]) m_b[i] = '0;
      return;
    end
    sz0 = mq.size();
    pop = (m_phase == 0) && (sz0 > 0);
    case (m_phase)
      0: if (pop) begin m_cur = mq.pop_front(); m_phase = 1; end
      1: begin
        m_phase = 0;
        c = m_cur[15:12]; a = m_cur[11:8]; p = m_cur[7:0];
        if (c == 4'd1) begin
          if (a < 8) m_b[a[2:0]] = p[7:1]; else m_err_bump();
        end else if (c == 4'd2) begin
          m_valid = 1; m_phase = 2;
          if (a < 8) m_frame = {c, a, m_b[a[2:0]], 1'b0};
          else begin m_frame = {c, a, 8'hFF}; m_err_bump(); end
        end else if (c != 4'd0) m_err_bump();
      end
      default: if (k) begin m_valid = 0; m_phase = 0; end
    endcase
    if (d) begin
      if (sz0 < 4 || pop) mq.push_back(f);
      else if (m_drop < 255) m_drop++;
    end
  endfunction

  function automatic logic [55:0] m_bus();
    logic [55:0] v = '0;
    for (int i = 0; i < 8; i++) v[7*i +: 7] = m_b[i];
    return v;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic r, input logic d, input logic [3:0] c,
                      input logic [3:0] a, input logic [7:0] p, input logic k);
    rst = r; dv = d; cmd = c; addr = a; pay = p; ack = k;
    @(posedge sysclk);
    model_step(r, d, {c, a, p}, k);
    #1;
    rst = 0; dv = 0; ack = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 4'd0, 4'd0, 8'd0, 0);
  endtask

  task automatic chk_model(input int cyc);
    string s;
    s = $sformatf("rand@%0d", cyc);
    chk({s, " valid"}, 64'(tx_valid), 64'(m_valid));
    if (m_valid) chk({s, " frame"}, 64'(tx_frame), 64'(m_frame));
    chk({s, " full"}, 64'(fifo_full), 64'(mq.size() == 4));
    chk({s, " err"}, 64'(err_cnt), 64'(m_err));
    chk({s, " drop"}, 64'(drop_cnt), 64'(m_drop));
    chk({s, " bright"}, 64'(bright), 64'(m_bus()));
  endtask

  function automatic logic [6:0] led(input int i);
    return bright[7*i +: 7];
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic r, d; logic [3:0] c, a; logic [7:0] p; logic k;
    logic ev; logic [15:0] ef; logic [7:0] ee; logic [55:0] eb;
  } vec_t;

  function automatic vec_t mkv(logic r, logic d, logic [3:0] c, logic [3:0] a,
                               logic [7:0] p, logic k, logic ev, logic [15:0] ef,
                               logic [7:0] ee, logic [55:0] eb);
    vec_t v;
    v.r = r; v.d = d; v.c = c; v.a = a; v.p = p; v.k = k;
    v.ev = ev; v.ef = ef; v.ee = ee; v.eb = eb;
    return v;
  endfunction

  initial begin
    vec_t tbl[20];
    logic [55:0] b3, b35;
    b3  = 56'h7F << 21;
    b35 = b3 | (56'h32 << 35);
    //              r  d  c     a     p      k  ev frame     err  bright
    tbl[0]  = mkv(1, 0, 4'd0, 4'd0, 8'h00, 0, 0, 16'h0000, 0, '0);
    tbl[1]  = mkv(0, 1, 4'd1, 4'd3, 8'hFE, 0, 0, 16'h0000, 0, '0);
    tbl[2]  = mkv(0, 0, 4'd0, 4'd0, 8'h00, 0, 0, 16'h0000, 0, '0);
    tbl[3]  = mkv(0, 0, 4'd0, 4'd0, 8'h00, 0, 0, 16'h0000, 0, b3);
    tbl[4]  = mkv(0, 1, 4'd1, 4'd5, 8'h64, 0, 0, 16'h0000, 0, b3);
    tbl[5]  = mkv(0, 1, 4'd2, 4'd5, 8'h00, 0, 0, 16'h0000, 0, b3);
    tbl[6]  = mkv(0, 0, 4'd0, 4'd0, 8'h00, 0, 0, 16'h0000, 0, b35);
    tbl[7]  = mkv(0, 0, 4'd0, 4'd0, 8'h00, 0, 0, 16'h0000, 0, b35);
    tbl[8]  = mkv(0, 0, 4'd0, 4'd0, 8'h00, 0, 1, 16'h2564, 0, b35);
    tbl[9]  = mkv(0, 0, 4'd0, 4'd0, 8'h00, 0, 1, 16'h2564, 0, b35);
    tbl[10] = mkv(0, 0, 4'd0, 4'd0, 8'h00, 0, 1, 16'h2564, 0, b35);
    tbl[11] = mkv(0, 0, 4'd0, 4'd0, 8'h00, 1, 0, 16'h0000, 0, b35);
    tbl[12] = mkv(0, 1, 4'd1, 4'd9, 8'h55, 0, 0, 16'h0000, 0, b35);
    tbl[13] = mkv(0, 1, 4'd2, 4'hC, 8'h00, 0, 0, 16'h0000, 0, b35);
    tbl[14] = mkv(0, 1, 4'd7, 4'd0, 8'h00, 0, 0, 16'h0000, 1, b35);
    tbl[15] = mkv(0, 0, 4'd0, 4'd0, 8'h00, 0, 0, 16'h0000, 1, b35);
    tbl[16] = mkv(0, 0, 4'd0, 4'd0, 8'h00, 0, 1, 16'h2CFF, 2, b35);
    tbl[17] = mkv(0, 0, 4'd0, 4'd0, 8'h00, 1, 0, 16'h0000, 2, b35);
    tbl[18] = mkv(0, 0, 4'd0, 4'd0, 8'h00, 0, 0, 16'h0000, 2, b35);
    tbl[19] = mkv(0, 0, 4'd0, 4'd0, 8'h00, 0, 0, 16'h0000, 3, b35);

    for (int i = 0; i < 20; i++) begin
      tick(tbl[i].r, tbl[i].d, tbl[i].c, tbl[i].a, tbl[i].p, tbl[i].k);
      chk($sformatf("vec%0d valid", i), 64'(tx_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("vec%0d frame", i), 64'(tx_frame), 64'(tbl[i].ef));
      chk($sformatf("vec%0d err", i), 64'(err_cnt), 64'(tbl[i].ee));
      chk($sformatf("vec%0d drop", i), 64'(drop_cnt), 64'(0));
      chk($sformatf("vec%0d bright", i), 64'(bright), 64'(tbl[i].eb));
    end
    chk("reset frame", 64'(tx_frame), 64'h2CFF);

    // ---- pending read, 10-cycle hold, overflow with drops, push+pop when full
    tick(1, 0, 4'd0, 4'd0, 8'h00, 0);
    chk("rst full", 64'(fifo_full), 64'(0));
    tick(0, 1, 4'd2, 4'd5, 8'h00, 0);
    idle(2);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold%0d valid", i), 64'(tx_valid), 64'(1));
      chk($sformatf("hold%0d frame", i), 64'(tx_frame), 64'h2500);
      idle(1);
    end
    for (int i = 0; i < 6; i++) tick(0, 1, 4'd1, 4'(i), 8'(2 * (i + 1)), 0);
    chk("ovf full", 64'(fifo_full), 64'(1));
    chk("ovf drop", 64'(drop_cnt), 64'(2));
    chk("ovf valid", 64'(tx_valid), 64'(1));
    tick(0, 0, 4'd0, 4'd0, 8'h00, 1);
    chk("ack valid", 64'(tx_valid), 64'(0));
    chk("ack full", 64'(fifo_full), 64'(1));
    tick(0, 1, 4'd1, 4'd6, 8'h0E, 0);   // push on the pop edge of a full queue
    chk("pp full", 64'(fifo_full), 64'(1));
    chk("pp drop", 64'(drop_cnt), 64'(2));
    for (int k = 0; k < 4; k++) begin
      idle(1);
      chk($sformatf("order%0d set", k), 64'(led(k)), 64'(k + 1));
      chk($sformatf("order%0d next", k), 64'(led(k + 1)), 64'(0));
      idle(1);
    end
    idle(1);
    chk("pp led6", 64'(led(6)), 64'(7));
    chk("drop led5", 64'(led(5)), 64'(0));
    chk("drain full", 64'(fifo_full), 64'(0));

    // ---- reset mid-response with two frames queued, dv coincident with rst
    tick(1, 0, 4'd0, 4'd0, 8'h00, 0);
    tick(0, 1, 4'd1, 4'd0, 8'hFE, 0);
    tick(0, 1, 4'd9, 4'd0, 8'h00, 0);
    tick(0, 1, 4'd2, 4'd1, 8'h00, 0);
    idle(8);
    chk("pre valid", 64'(tx_valid), 64'(1));
    chk("pre frame", 64'(tx_frame), 64'h2100);
    chk("pre err", 64'(err_cnt), 64'(1));
    chk("pre led0", 64'(led(0)), 64'h7F);
    tick(0, 1, 4'd1, 4'd2, 8'hFE, 0);
    tick(0, 1, 4'd1, 4'd3, 8'hFE, 0);
    tick(1, 1, 4'd1, 4'd4, 8'hFE, 0);
    chk("rr valid", 64'(tx_valid), 64'(0));
    chk("rr frame", 64'(tx_frame), 64'(0));
    chk("rr full", 64'(fifo_full), 64'(0));
    chk("rr err", 64'(err_cnt), 64'(0));
    chk("rr drop", 64'(drop_cnt), 64'(0));
    chk("rr bright", 64'(bright), 64'(0));
    idle(6);
    chk("rr empty bright", 64'(bright), 64'(0));
    chk("rr empty valid", 64'(tx_valid), 64'(0));

    // ---- counter saturation
    tick(1, 0, 4'd0, 4'd0, 8'h00, 0);
    tick(0, 1, 4'd2, 4'd0, 8'h00, 0);
    idle(2);
    for (int i = 0; i < 300; i++) tick(0, 1, 4'd1, 4'd1, 8'h10, 0);
    chk("sat drop", 64'(drop_cnt), 64'(255));
    tick(1, 0, 4'd0, 4'd0, 8'h00, 0);
    for (int i = 0; i < 260; i++) begin
      tick(0, 1, 4'hF, 4'd0, 8'h00, 0);
      idle(1);
    end
    idle(3);
    chk("sat err", 64'(err_cnt), 64'(255));

    // ---- randomized run against the model
    tick(1, 0, 4'd0, 4'd0, 8'h00, 0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic r, d, k;
      logic [3:0] c, a;
      int sel;
      r = ($urandom_range(0, 299) == 0);
      d = ($urandom_range(0, 9) < 5);
      sel = $urandom_range(0, 9);
      if (sel < 4)      c = 4'd1;
      else if (sel < 7) c = 4'd2;
      else if (sel < 8) c = 4'd0;
      else              c = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 15));
      k = ($urandom_range(0, 3) == 0);
      tick(r, d, c, a, 8'($urandom_range(0, 255)), k);
      chk_model(cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_cmd_ctrl.md
LED_CMD_CTRL -- requirements
Module: led_cmd_ctrl

Interface
REQ-001 CMD_W, default 4, command field width.
REQ-002 ADDR_W, default 4, LED address field width.
REQ-003 PAYLOAD_W, default 8, payload field width; brightness = payload[7:1].
REQ-004 NUM_LEDS, default 8, number of brightness registers.
REQ-005 FIFO_DEPTH, default 4, command queue depth (power of two).
REQ-006 Command encodings SHALL be NOP=0, LED_SET=1, LED_READ=2; all others are illegal.
REQ-007 sysclk  in  1  sole clock; all logic on rising edge.
REQ-008 rst  in  1  reset; synchronous, active-high.
REQ-009 i_rx_dv  in  1  one-cycle pulse, decoded SPI frame valid.
REQ-010 i_cmd / i_addr / i_payload  in  CMD_W / ADDR_W / PAYLOAD_W  frame fields, valid with i_rx_dv.
REQ-011 i_tx_ack  in  1  SPI slave has taken o_tx_frame.
REQ-012 o_tx_valid  out  1  response frame pending.
REQ-013 o_tx_frame  out  CMD_W+ADDR_W+PAYLOAD_W  response {cmd, addr, payload}.
REQ-014 o_brightness  out  NUM_LEDS*7  flat brightness bus, LED n at [7n+6:7n], to PWM bank.
REQ-015 o_fifo_full  out  1  queue full.
REQ-016 o_err_cnt  out  8  illegal command / address count.
REQ-017 o_drop_cnt  out  8  frames dropped on full queue.

Function
REQ-018 Queue: on i_rx_dv with queue not full, {cmd,addr,payload} SHALL be written at that edge; with queue full, frame discarded and o_drop_cnt incremented.
REQ-019 Simultaneous push and pop SHALL both occur; count unchanged; full push with same-cycle pop SHALL be accepted.
REQ-020 Pointers SHALL wrap modulo FIFO_DEPTH; o_fifo_full = (count==FIFO_DEPTH).
REQ-021 FSM states: IDLE, EXEC, RESP.
REQ-022 IDLE: if queue non-empty, pop head into cmd/addr/payload holding regs, go EXEC; else stay.
REQ-023 EXEC (one cycle), then IDLE unless noted:
 - LED_SET, addr<NUM_LEDS: brightness[addr] <= payload[7:1].
 - LED_SET, addr>=NUM_LEDS: no write, o_err_cnt+1.
 - LED_READ, addr<NUM_LEDS: o_tx_frame <= {cmd, addr, brightness[addr], 1'b0}, o_tx_valid <= 1, go RESP.
 - LED_READ, addr>=NUM_LEDS: o_tx_frame <= {cmd, addr, 8'hFF}, o_tx_valid <= 1, o_err_cnt+1, go RESP.
 - NOP: no action.
 - illegal cmd: o_err_cnt+1, no other action.
REQ-024 RESP: o_tx_valid and o_tx_frame SHALL hold until i_tx_ack sampled high; that edge clears o_tx_valid, go IDLE. i_tx_ack outside RESP ignored.
REQ-025 Latency: i_rx_dv at edge k into empty queue with FSM in IDLE -> pop at edge k+1 -> brightness / o_tx_valid updated at edge k+2.
REQ-026 Queue accepts frames in every state, including RESP.
REQ-027 Throughput: one command per 2 cycles when no response is pending.
REQ-028 o_err_cnt and o_drop_cnt SHALL saturate at 255.
REQ-029 Brightness registers change only in EXEC; o_brightness is a direct register output.

Reset
REQ-030 rst at any edge, including mid-RESP or mid-EXEC, SHALL force:
 - FSM to IDLE, queue empty, o_fifo_full=0.
 - o_tx_valid=0, o_tx_frame=0.
 - all brightness=0, o_err_cnt=0, o_drop_cnt=0.
REQ-031 i_rx_dv coincident with rst SHALL be discarded.

Verification
REQ-032 SET addr=3 payload=8'hFE -> 2 cycles later o_brightness[27:21]=7'h7F; other LEDs 0.
REQ-033 SET addr=5 payload=8'h64, then READ addr=5 -> o_tx_valid=1, o_tx_frame=16'h2564; held 10 cycles with i_tx_ack=0; cleared on edge after ack.
REQ-034 SET addr=9, READ addr=12, cmd=7 -> o_err_cnt=3; brightness unchanged; READ frame=16'h2CFF.
REQ-035 READ pending (no ack) plus 6 back-to-back frames -> 4 queued, o_fifo_full=1, o_drop_cnt=2; after ack all 4 execute in order.
REQ-036 Push and pop in the same cycle with queue full -> accepted, count stays 4, o_drop_cnt unchanged.
REQ-037 rst asserted while in RESP with queue holding 2 entries -> next cycle o_tx_valid=0, queue empty, all brightness and counters 0.
